// File: rtl/barrel_pkg.sv
// Shared definitions for the bidirectional barrel shifter pipeline.
// Optional build macro: BARREL_FLAGS_EN (adds the registered out_zero flag).
package barrel_pkg;

  // Operation selector carried alongside every word in flight.
  typedef enum logic [1:0] {
    MODE_ROT  = 2'b00,
    MODE_LSH  = 2'b01,
    MODE_ASH  = 2'b10,
    MODE_CROT = 2'b11
  } mode_e;

  // Shift-amount width, which is also the number of pipeline stages.
  // A 1-bit floor keeps port widths legal for the smallest word size.
  function automatic int shw_of(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/barrel_stage.sv
// One pipeline stage: conditionally shifts/rotates its word by AMT and
// registers the result together with the operation context.
// Handshake: a word moves from in_* into this stage at a rising edge when
// in_valid && in_ready; in_ready = !out_valid || out_ready, so a full stage
// can be refilled in the same cycle its word leaves downstream.
module barrel_stage
  import barrel_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int AMT   = 1,
  localparam int SHW   = shw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
  input  logic [SHW-1:0]   in_sel,
  input  logic             in_left,
  input  logic [1:0]       in_mode,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic [SHW-1:0]   out_sel,
  output logic             out_left,
  output logic [1:0]       out_mode,
  output logic             out_sign,
  output logic [WIDTH-1:0] nxt_word
);

  // Which shift-amount bit this stage resolves.
  localparam int BIT = $clog2(AMT);

  logic [WIDTH-1:0] rot_l;
  logic [WIDTH-1:0] rot_r;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] shr;
  logic [AMT-1:0]   fill;

  // Shift/rotate by AMT when this stage's sel bit is set; right shifts fill
  // with the captured sign in arithmetic mode, zero otherwise.
  always_comb begin
    rot_l = {in_word[WIDTH-AMT-1:0], in_word[WIDTH-1:WIDTH-AMT]};
    rot_r = {in_word[AMT-1:0], in_word[WIDTH-1:AMT]};
    fill  = (in_mode == MODE_ASH) ? {AMT{in_sign}} : '0;
    shl   = {in_word[WIDTH-AMT-1:0], {AMT{1'b0}}};
    shr   = {fill, in_word[WIDTH-1:AMT]};
    nxt_word = in_word;
    if (in_sel[BIT]) begin
      case (in_mode)
        MODE_ROT, MODE_CROT: nxt_word = in_left ? rot_l : rot_r;
        default:             nxt_word = in_left ? shl : shr;
      endcase
    end
  end

  assign in_ready = !out_valid || out_ready;

  // Stage register: advances whenever the slot is empty or being drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_word  <= '0;
      out_sel   <= '0;
      out_left  <= 1'b0;
      out_mode  <= 2'b00;
      out_sign  <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_word <= nxt_word;
        out_sel  <= in_sel;
        out_left <= in_left;
        out_mode <= in_mode;
        out_sign <= in_sign;
      end
    end
  end

endmodule

// File: rtl/bidir_barrel_pipe.sv
// Pipelined bidirectional barrel shifter/rotator, one shift-amount bit per
// stage, SHW stages deep, one word per cycle.
// Optional build macro: BARREL_FLAGS_EN adds out_zero, registered with out.
// Handshake: input transfer on in_valid && in_ready, output transfer on
// out_valid && out_ready, both at a rising edge; out holds while stalled.
module bidir_barrel_pipe
  import barrel_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = shw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   sel,
  input  logic             left,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef BARREL_FLAGS_EN
  output logic             out_zero,
`endif
  output logic [WIDTH-1:0] out
);

  logic             valid_q  [SHW];
  logic             ready_up [SHW];
  logic             v_in     [SHW];
  logic [WIDTH-1:0] word_q   [SHW];
  logic [WIDTH-1:0] nxt_w    [SHW];
  logic [SHW-1:0]   sel_q    [SHW];
  logic             left_q   [SHW];
  logic [1:0]       mode_q   [SHW];
  logic             sign_q   [SHW];

  generate
    for (genvar k = 0; k < SHW; k++) begin : g_stage
      logic [WIDTH-1:0] w_src;
      logic [WIDTH-1:0] w_in;
      logic [SHW-1:0]   s_in;
      logic             l_in;
      logic [1:0]       m_in;
      logic             g_in;
      logic             rdy_dn;

      if (k == 0) begin : g_first
        // Input capture: the sign is taken from the operand as it enters.
        assign v_in[k] = in_valid;
        assign w_src   = data;
        assign s_in    = sel;
        assign l_in    = left;
        assign m_in    = mode;
        assign g_in    = data[WIDTH-1];
      end else begin : g_mid
        assign v_in[k] = valid_q[k-1];
        assign w_src   = word_q[k-1];
        assign s_in    = sel_q[k-1];
        assign l_in    = left_q[k-1];
        assign m_in    = mode_q[k-1];
        assign g_in    = sign_q[k-1];
      end

      if (k == SHW - 1) begin : g_last
        // Inversion commutes with rotation, so it is applied once here.
        assign w_in   = (m_in == MODE_CROT) ? ~w_src : w_src;
        assign rdy_dn = out_ready;
        logic unused_last;
        assign unused_last = ^{sel_q[k], left_q[k], mode_q[k], sign_q[k], nxt_w[k]};
      end else begin : g_inner
        assign w_in   = w_src;
        assign rdy_dn = ready_up[k+1];
        logic unused_nxt;
        assign unused_nxt = ^nxt_w[k];
      end

      barrel_stage #(
        .WIDTH (WIDTH),
        .AMT   (1 << k)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v_in[k]),
        .in_ready  (ready_up[k]),
        .in_word   (w_in),
        .in_sel    (s_in),
        .in_left   (l_in),
        .in_mode   (m_in),
        .in_sign   (g_in),
        .out_valid (valid_q[k]),
        .out_ready (rdy_dn),
        .out_word  (word_q[k]),
        .out_sel   (sel_q[k]),
        .out_left  (left_q[k]),
        .out_mode  (mode_q[k]),
        .out_sign  (sign_q[k]),
        .nxt_word  (nxt_w[k])
      );
    end
  endgenerate

  assign in_ready  = ready_up[0];
  assign out_valid = valid_q[SHW-1];
  assign out       = word_q[SHW-1];

`ifdef BARREL_FLAGS_EN
  logic zero_q;

  // Zero flag loads in lockstep with the last stage word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else if (ready_up[SHW-1] && v_in[SHW-1]) begin
      zero_q <= (nxt_w[SHW-1] == '0);
    end
  end

  assign out_zero = zero_q;
`endif

endmodule

// File: tb/tb_bidir_barrel_pipe.sv
// Bench for bidir_barrel_pipe: WIDTH=8 main instance, WIDTH=16 latency
// instance. Define BARREL_FLAGS_EN to also check out_zero.
module tb_bidir_barrel_pipe;

  localparam int SW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=8 instance signals
  logic       in_valid, in_ready, left, out_valid, out_ready;
  logic [7:0] data, out;
  logic [2:0] sel;
  logic [1:0] mode;
`ifdef BARREL_FLAGS_EN
  logic       out_zero;
`endif

  // WIDTH=16 instance signals
  logic        in_valid16, in_ready16, left16, out_valid16, out_ready16;
  logic [15:0] data16, out16;
  logic [3:0]  sel16;
  logic [1:0]  mode16;
`ifdef BARREL_FLAGS_EN
  logic        out_zero16;
`endif

  bidir_barrel_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data      (data),
    .sel       (sel),
    .left      (left),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef BARREL_FLAGS_EN
    .out_zero  (out_zero),
`endif
    .out       (out)
  );

  bidir_barrel_pipe #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .data      (data16),
    .sel       (sel16),
    .left      (left16),
    .mode      (mode16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
`ifdef BARREL_FLAGS_EN
    .out_zero  (out_zero16),
`endif
    .out       (out16)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic [2:0] sel;
    logic       left;
    logic [1:0] mode;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Independent reference: rotations via a doubled word, shifts via operators.
  function automatic logic [7:0] ref_model(input logic [7:0] d, input logic [2:0] s,
                                           input logic l, input logic [1:0] m);
    logic [15:0] dd;
    logic [7:0]  r;
    dd = {d, d};
    if (m == 2'b00 || m == 2'b11) begin
      if (l) begin
        dd = dd << s;
        r  = dd[15:8];
      end else begin
        dd = dd >> s;
        r  = dd[7:0];
      end
      if (m == 2'b11) r = ~r;
    end else if (l) begin
      r = d << s;
    end else if (m == 2'b10) begin
      r = 8'($signed(d) >>> s);
    end else begin
      r = d >> s;
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_one(input vec_t v, input string name);
    int n;
    @(negedge clk);
    data = v.data; sel = v.sel; left = v.left; mode = v.mode;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'(SW - 1));
    check({name, "_out"}, 32'(out), 32'(v.exp));
`ifdef BARREL_FLAGS_EN
    check({name, "_zero"}, 32'(out_zero), 32'(v.exp == 8'h00));
`endif
  endtask

  task automatic send16(input logic [15:0] d, input logic [3:0] s, input logic l,
                        input logic [1:0] m, input logic [15:0] exp, input string name);
    int n;
    @(negedge clk);
    data16 = d; sel16 = s; left16 = l; mode16 = m; in_valid16 = 1'b1;
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    n = 0;
    while (!out_valid16 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'd3);
    check({name, "_out"}, 32'(out16), 32'(exp));
  endtask

  // Stream nwords random words; rnd_ready toggles out_ready, otherwise it
  // is held high and every cycle must accept a word.
  task automatic stream(input int nwords, input bit rnd_ready, input string name);
    int sent, got, cyc;
    logic stalled, acc_in, acc_out;
    logic [7:0] held;
    sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = 8'h00;
    while ((sent < nwords || got < nwords) && cyc < 400) begin
      @(negedge clk);
      out_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (sent < nwords && !in_valid) begin
        data = 8'($urandom_range(0, 255));
        sel  = 3'($urandom_range(0, 7));
        left = 1'($urandom_range(0, 1));
        mode = 2'($urandom_range(0, 3));
        in_valid = 1'b1;
      end
      #1;
      if (stalled) begin
        check({name, "_stall_out"}, 32'(out), 32'(held));
        check({name, "_stall_valid"}, 32'(out_valid), 32'd1);
      end
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (!rnd_ready && in_valid) check({name, "_full_rate"}, 32'(in_ready), 32'd1);
      if (acc_out) begin
        if (exp_q.size() == 0) check({name, "_extra_out"}, 32'(out), 32'hDEAD);
        else check({name, "_out"}, 32'(out), 32'(exp_q.pop_front()));
        got++;
      end
      stalled = out_valid && !out_ready;
      held    = out;
      if (acc_in) begin
        exp_q.push_back(ref_model(data, sel, left, mode));
        sent++;
      end
      @(posedge clk);
      #1;
      if (acc_in) in_valid = 1'b0;
      cyc++;
    end
    check({name, "_count"}, 32'(got), 32'(nwords));
    check({name, "_leftover"}, 32'(exp_q.size()), 32'd0);
    if (!rnd_ready) check({name, "_cycles"}, 32'(cyc), 32'(nwords + SW));
    exp_q.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int acc;
    int seen;

    vecs[0]  = '{8'hA5, 3'd1, 1'b0, 2'b00, 8'hD2};
    vecs[1]  = '{8'hA5, 3'd5, 1'b1, 2'b00, 8'hB4};
    vecs[2]  = '{8'hA5, 3'd3, 1'b0, 2'b01, 8'h14};
    vecs[3]  = '{8'hA5, 3'd3, 1'b0, 2'b10, 8'hF4};
    vecs[4]  = '{8'hA5, 3'd3, 1'b1, 2'b01, 8'h28};
    vecs[5]  = '{8'hA5, 3'd3, 1'b1, 2'b10, 8'h28};
    vecs[6]  = '{8'hA5, 3'd5, 1'b1, 2'b11, 8'h4B};
    vecs[7]  = '{8'hA5, 3'd0, 1'b1, 2'b00, 8'hA5};
    vecs[8]  = '{8'hA5, 3'd0, 1'b0, 2'b11, 8'h5A};
    vecs[9]  = '{8'h80, 3'd7, 1'b0, 2'b10, 8'hFF};
    vecs[10] = '{8'h80, 3'd1, 1'b1, 2'b01, 8'h00};
    vecs[11] = '{8'h80, 3'd1, 1'b1, 2'b00, 8'h01};
    vecs[12] = '{8'h3C, 3'd4, 1'b0, 2'b01, 8'h03};
    vecs[13] = '{8'h01, 3'd7, 1'b0, 2'b00, 8'h02};
    vecs[14] = '{8'h7F, 3'd2, 1'b0, 2'b10, 8'h1F};

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; data = 8'h00; sel = 3'd0; left = 1'b0; mode = 2'b00;
    in_valid16 = 1'b0; out_ready16 = 1'b1; data16 = 16'h0000; sel16 = 4'd0;
    left16 = 1'b0; mode16 = 2'b00;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out", 32'(out), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid16", 32'(out_valid16), 32'd0);
`ifdef BARREL_FLAGS_EN
    check("reset_zero", 32'(out_zero), 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_in_ready", 32'(in_ready), 32'd1);

    // Directed table.
    for (int i = 0; i < 15; i++) send_one(vecs[i], $sformatf("vec%0d", i));

    // Wider word: four stages.
    send16(16'h8001, 4'd15, 1'b1, 2'b00, 16'hC000, "w16_rotl15");
    send16(16'h8001, 4'd15, 1'b0, 2'b10, 16'hFFFF, "w16_ashr15");

    // Streams: random backpressure, then sustained full rate.
    stream(20, 1'b1, "rand_stream");
    stream(10, 1'b0, "full_stream");

    // Fill with the consumer stalled: exactly SW words fit.
    @(negedge clk);
    out_ready = 1'b0;
    data = 8'hA5; sel = 3'd1; left = 1'b0; mode = 2'b00; in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (in_ready) acc++;
      @(negedge clk);
    end
    check("fill_accepts", 32'(acc), 32'(SW));
    check("fill_in_ready", 32'(in_ready), 32'd0);
    check("fill_out_valid", 32'(out_valid), 32'd1);
    check("fill_out", 32'(out), 32'hD2);

    // Reset mid-stream, away from any edge.
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out", 32'(out), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("no_stale_after_reset", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
